// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory: byte-addressed fetches with one cycle of registered
// latency, plus a valid/ready streaming load port that replaces the program image.
module inst_mem_loadable #(
    parameter int                DEPTH_LOG2   = 8,
    parameter int                DATA_W       = 32,
    parameter logic [DATA_W-1:0] DEFAULT_WORD = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    output logic                  fetch_valid,
    output logic [DATA_W-1:0]     fetch_instr,
    output logic                  fetch_err,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_W-1:0]     load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  busy,
    output logic                  load_ovf,
    output logic [DEPTH_LOG2:0]   load_words
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_MAX   = '1;
    localparam logic [DEPTH_LOG2:0]   WORDS_ONE = 1;

    typedef enum logic {RUN, LOAD} state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   ptr_q, ptr_d;
    logic [DEPTH_LOG2:0]     words_q, words_d;
    logic                    ovf_q, ovf_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic                    fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0]       fetch_instr_q, fetch_instr_d;
    logic                    fetch_err_q, fetch_err_d;

    logic [DATA_W-1:0]       mem [DEPTH];
    logic                    wr_en;
    logic [DEPTH_LOG2-1:0]   fetch_idx;
    logic                    fetch_bad;

    assign fetch_idx = fetch_addr[DEPTH_LOG2+1:2];
    assign fetch_bad = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (DEPTH_LOG2 + 2)) != 32'd0);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        words_d       = words_q;
        ovf_d         = ovf_q;
        valid_d       = valid_q;
        fetch_valid_d = 1'b0;
        fetch_instr_d = fetch_instr_q;
        fetch_err_d   = fetch_err_q;
        wr_en         = 1'b0;

        // A start (or restart) takes priority over both a fetch and an incoming word.
        if (load_start) begin
            state_d = LOAD;
            ptr_d   = '0;
            words_d = '0;
            ovf_d   = 1'b0;
            valid_d = '0;
        end else if (state_q == RUN) begin
            if (fetch_req) begin
                fetch_valid_d = 1'b1;
                fetch_err_d   = fetch_bad;
                if (!fetch_bad && valid_q[fetch_idx]) begin
                    fetch_instr_d = mem[fetch_idx];
                end else begin
                    fetch_instr_d = DEFAULT_WORD;
                end
            end
        end else if (load_valid) begin
            wr_en          = 1'b1;
            valid_d[ptr_q] = 1'b1;
            ptr_d          = ptr_q + PTR_ONE;
            words_d        = words_q + WORDS_ONE;
            if (load_last) begin
                state_d = RUN;
            end else if (ptr_q == PTR_MAX) begin
                state_d = RUN;
                ovf_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            ptr_q         <= '0;
            words_q       <= '0;
            ovf_q         <= 1'b0;
            valid_q       <= '0;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= DEFAULT_WORD;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            words_q       <= words_d;
            ovf_q         <= ovf_d;
            valid_q       <= valid_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // Storage carries no reset; the valid bits alone decide what reads back.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q] <= load_data;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_err   = fetch_err_q;
    assign busy        = (state_q == LOAD);
    assign load_ready  = (state_q == LOAD);
    assign load_ovf    = ovf_q;
    assign load_words  = words_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Randomised bench for inst_mem_loadable; the reference model keeps the program
// image as a queue of words that is cleared on reset and on every load start.
module tb_inst_mem_loadable;

    localparam int DEPTH_LOG2 = 8;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_err;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        busy;
    logic        load_ovf;
    logic [8:0]  load_words;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] img[$];
    logic [31:0] stage[$];

    inst_mem_loadable #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(32), .DEFAULT_WORD(32'h0)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_err(fetch_err),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .busy(busy),
        .load_ovf(load_ovf), .load_words(load_words)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_fetch(input logic [31:0] a, output logic [31:0] ins, output logic er);
        int idx;
        if (a[1:0] != 2'b00 || (a >> (DEPTH_LOG2 + 2)) != 32'd0) begin
            ins = 32'h0;
            er  = 1'b1;
        end else begin
            idx = int'(a >> 2);
            er  = 1'b0;
            ins = (idx < img.size()) ? img[idx] : 32'h0;
        end
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 4))
            0, 1, 2: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            3:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            default: a = ($urandom & ~32'h3) | 32'h0000_0400;
        endcase
        return a;
    endfunction

    task automatic do_fetch(input logic [31:0] a, output logic v, output logic [31:0] ins, output logic er);
        fetch_req  = 1'b1;
        fetch_addr = a;
        step();
        fetch_req  = 1'b0;
        v   = fetch_valid;
        ins = fetch_instr;
        er  = fetch_err;
    endtask

    // Streams the staged words as one image with load_last on the final word.
    task automatic load_stage();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        img.delete();
        foreach (stage[i]) begin
            load_valid = 1'b1;
            load_data  = stage[i];
            load_last  = (i == stage.size() - 1);
            step();
            img.push_back(stage[i]);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_valid: got %b, expected 0", fetch_valid); end
        n_tests++; if (fetch_instr !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_instr: got %h, expected 0", fetch_instr); end
        n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_err: got %b, expected 0", fetch_err); end
        n_tests++; if (load_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ready_busy: got %b%b, expected 00", load_ready, busy); end
        n_tests++; if (load_ovf !== 1'b0 || load_words !== 9'd0) begin n_fail++; $display("FAIL reset_ovf_words: got %b/%0d, expected 0/0", load_ovf, load_words); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        img.delete();
    endtask

    task automatic test_fetch_after_reset();
        logic v, er;
        logic [31:0] ins;
        logic [31:0] addrs[3] = '{32'h0, 32'h40, 32'h3FC};
        foreach (addrs[i]) begin
            do_fetch(addrs[i], v, ins, er);
            n_tests++;
            if (v !== 1'b1 || ins !== 32'h0 || er !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_after_reset@%h: got v=%b i=%h e=%b, expected v=1 i=0 e=0", addrs[i], v, ins, er);
            end
        end
    endtask

    task automatic test_load_fetch();
        logic v, er, exp_er;
        logic [31:0] ins, exp_ins, held;
        stage = '{32'h0800_0010, 32'h0800_0060, 32'h3C0D_4000};
        load_stage();
        n_tests++; if (load_words !== 9'd3) begin n_fail++; $display("FAIL load_words3: got %0d, expected 3", load_words); end
        n_tests++; if (busy !== 1'b0 || load_ready !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b%b, expected 00", busy, load_ready); end
        do_fetch(32'h8, v, ins, er);
        n_tests++; if (v !== 1'b1 || ins !== 32'h3C0D_4000 || er !== 1'b0) begin n_fail++; $display("FAIL fetch_0x8: got v=%b i=%h e=%b, expected v=1 i=3c0d4000 e=0", v, ins, er); end
        do_fetch(32'hC, v, ins, er);
        n_tests++; if (v !== 1'b1 || ins !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL fetch_0xC: got v=%b i=%h e=%b, expected v=1 i=0 e=0", v, ins, er); end
        do_fetch(32'h4, v, ins, er);
        model_fetch(32'h4, exp_ins, exp_er);
        n_tests++; if (ins !== exp_ins || er !== exp_er) begin n_fail++; $display("FAIL fetch_0x4: got %h/%b, expected %h/%b", ins, er, exp_ins, exp_er); end
        held = ins;
        step();
        n_tests++; if (fetch_valid !== 1'b0 || fetch_instr !== held) begin n_fail++; $display("FAIL instr_hold: got v=%b i=%h, expected v=0 i=%h", fetch_valid, fetch_instr, held); end
    endtask

    task automatic test_fetch_errors();
        logic v, er;
        logic [31:0] ins;
        logic [31:0] addrs[4] = '{32'h402, 32'h400, 32'h3, 32'h8000_0000};
        foreach (addrs[i]) begin
            do_fetch(addrs[i], v, ins, er);
            n_tests++;
            if (v !== 1'b1 || ins !== 32'h0 || er !== 1'b1) begin
                n_fail++;
                $display("FAIL fetch_err@%h: got v=%b i=%h e=%b, expected v=1 i=0 e=1", addrs[i], v, ins, er);
            end
        end
    endtask

    task automatic test_random_load();
        logic v, er, exp_er;
        logic [31:0] ins, exp_ins, a;
        int n;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 60);
            stage.delete();
            for (int k = 0; k < n; k++) stage.push_back($urandom);
            load_stage();
            n_tests++; if (load_words !== 9'(n)) begin n_fail++; $display("FAIL rand_words: got %0d, expected %0d", load_words, n); end
            for (int k = 0; k < 12; k++) begin
                a = (k < 6) ? (32'($urandom_range(0, n + 2)) << 2) : rand_addr();
                do_fetch(a, v, ins, er);
                model_fetch(a, exp_ins, exp_er);
                n_tests++;
                if (v !== 1'b1 || ins !== exp_ins || er !== exp_er) begin
                    n_fail++;
                    $display("FAIL rand_fetch@%h: got v=%b i=%h e=%b, expected v=1 i=%h e=%b", a, v, ins, er, exp_ins, exp_er);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev, exp_ins;
        logic exp_er;
        prev = rand_addr();
        fetch_req  = 1'b1;
        fetch_addr = prev;
        for (int k = 0; k < 10; k++) begin
            step();
            model_fetch(prev, exp_ins, exp_er);
            n_tests++;
            if (fetch_valid !== 1'b1 || fetch_instr !== exp_ins || fetch_err !== exp_er) begin
                n_fail++;
                $display("FAIL b2b@%h: got v=%b i=%h e=%b, expected v=1 i=%h e=%b", prev, fetch_valid, fetch_instr, fetch_err, exp_ins, exp_er);
            end
            prev = rand_addr();
            fetch_addr = prev;
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_overflow();
        logic v, er;
        logic [31:0] ins;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        img.delete();
        for (int k = 0; k < DEPTH + 1; k++) begin
            load_valid = 1'b1;
            load_last  = 1'b0;
            load_data  = $urandom;
            if (k < DEPTH) img.push_back(load_data);
            step();
            n_tests++;
            if (load_ready !== (k < DEPTH - 1)) begin
                n_fail++;
                $display("FAIL ovf_ready word %0d: got %b, expected %b", k, load_ready, (k < DEPTH - 1));
            end
        end
        load_valid = 1'b0;
        n_tests++; if (load_ovf !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ovf_flag: got ovf=%b busy=%b, expected 1/0", load_ovf, busy); end
        n_tests++; if (load_words !== 9'd256) begin n_fail++; $display("FAIL ovf_words: got %0d, expected 256", load_words); end
        do_fetch(32'h3FC, v, ins, er);
        n_tests++; if (v !== 1'b1 || ins !== img[255] || er !== 1'b0) begin n_fail++; $display("FAIL ovf_fetch_3fc: got v=%b i=%h e=%b, expected v=1 i=%h e=0", v, ins, er, img[255]); end
        do_fetch(32'h0, v, ins, er);
        n_tests++; if (ins !== img[0] || er !== 1'b0) begin n_fail++; $display("FAIL ovf_fetch_0: got %h/%b, expected %h/0", ins, er, img[0]); end
    endtask

    task automatic test_restart();
        logic v, er;
        logic [31:0] ins, wa, wb;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            load_valid = 1'b1;
            load_data  = $urandom | 32'h1;
            step();
        end
        n_tests++; if (load_words !== 9'd5) begin n_fail++; $display("FAIL restart_pre_words: got %0d, expected 5", load_words); end
        load_start = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        step();
        load_start = 1'b0;
        img.delete();
        n_tests++; if (load_words !== 9'd0 || busy !== 1'b1 || load_ovf !== 1'b0) begin n_fail++; $display("FAIL restart_state: got words=%0d busy=%b ovf=%b, expected 0/1/0", load_words, busy, load_ovf); end
        wa = $urandom;
        wb = $urandom;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        load_data  = wa;
        step();
        fetch_req  = 1'b0;
        img.push_back(wa);
        n_tests++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_in_load: got fetch_valid=%b, expected 0", fetch_valid); end
        load_data = wb;
        load_last = 1'b1;
        step();
        img.push_back(wb);
        load_valid = 1'b0;
        load_last  = 1'b0;
        n_tests++; if (load_words !== 9'd2 || busy !== 1'b0) begin n_fail++; $display("FAIL restart_done: got words=%0d busy=%b, expected 2/0", load_words, busy); end
        do_fetch(32'h4, v, ins, er);
        n_tests++; if (ins !== wb || er !== 1'b0) begin n_fail++; $display("FAIL restart_new_word: got %h, expected %h", ins, wb); end
        do_fetch(32'h8, v, ins, er);
        n_tests++; if (ins !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL restart_stale_8: got %h, expected 0", ins); end
        do_fetch(32'h10, v, ins, er);
        n_tests++; if (ins !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL restart_stale_10: got %h, expected 0", ins); end
    endtask

    task automatic test_start_with_fetch();
        logic v, er;
        logic [31:0] ins, w;
        load_start = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        step();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        img.delete();
        n_tests++; if (fetch_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL start_vs_fetch: got v=%b busy=%b, expected 0/1", fetch_valid, busy); end
        w = $urandom | 32'h8000_0000;
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_data  = w;
        step();
        img.push_back(w);
        load_valid = 1'b0;
        load_last  = 1'b0;
        do_fetch(32'h0, v, ins, er);
        n_tests++; if (v !== 1'b1 || ins !== w || load_words !== 9'd1) begin n_fail++; $display("FAIL single_word: got v=%b i=%h words=%0d, expected 1/%h/1", v, ins, load_words, w); end
    endtask

    task automatic test_reset_midload();
        logic v, er;
        logic [31:0] ins;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1;
            load_data  = $urandom;
            step();
        end
        #3;
        reset = 1'b0;
        load_valid = 1'b0;
        img.delete();
        #1;
        n_tests++; if (busy !== 1'b0 || load_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got busy=%b ready=%b, expected 0/0", busy, load_ready); end
        n_tests++; if (load_words !== 9'd0 || load_ovf !== 1'b0) begin n_fail++; $display("FAIL midreset_words: got %0d/%b, expected 0/0", load_words, load_ovf); end
        n_tests++; if (fetch_valid !== 1'b0 || fetch_instr !== 32'h0 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL midreset_fetch_out: got v=%b i=%h e=%b, expected 0/0/0", fetch_valid, fetch_instr, fetch_err); end
        #2;
        reset = 1'b1;
        step();
        do_fetch(32'h0, v, ins, er);
        n_tests++; if (v !== 1'b1 || ins !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL midreset_fetch0: got v=%b i=%h e=%b, expected 1/0/0", v, ins, er); end
        do_fetch(32'h4, v, ins, er);
        n_tests++; if (ins !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL midreset_fetch4: got %h/%b, expected 0/0", ins, er); end
    endtask

    initial begin
        reset      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 32'h0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 32'h0;
        load_last  = 1'b0;
        test_reset();
        test_fetch_after_reset();
        test_load_fetch();
        test_fetch_errors();
        test_random_load();
        test_back_to_back();
        test_overflow();
        test_restart();
        test_start_with_fetch();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_mem_loadable.md
# inst_mem_loadable

Parametrised, loadable instruction memory for the MIPS CPU: the successor to the fixed, combinational program ROM. It holds `2**DEPTH_LOG2` 32-bit words in a synchronous array, serves byte-addressed instruction fetches with one cycle of registered latency, and accepts a new program image streamed in word by word through a valid/ready load port. Words not written since reset or since the last load start read back as `DEFAULT_WORD` (nop), so the CPU always fetches defined contents.

## Interface
- `DEPTH_LOG2`, 8, log2 of the word count; addressable words are 0..2**DEPTH_LOG2-1.
- `DATA_W`, 32, instruction width in bits.
- `DEFAULT_WORD`, 32'h00000000, value returned for unwritten, out-of-range or misaligned fetches.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. Asserting it (0) clears all state immediately; the block leaves reset on the edge after deassertion.
- `fetch_req` in 1: fetch request, sampled on the clock edge.
- `fetch_addr` in 32: byte address of the instruction to fetch.
- `fetch_valid` out 1: `fetch_instr` and `fetch_err` are valid this cycle.
- `fetch_instr` out DATA_W: fetched instruction.
- `fetch_err` out 1: the fetch was misaligned or out of range.
- `load_start` in 1: begin a load session, starting at word 0.
- `load_valid` in 1: `load_data` is presented.
- `load_data` in DATA_W: program word to write.
- `load_last` in 1: qualifies `load_data` as the final word of the image.
- `load_ready` out 1: the block accepts a load word this cycle.
- `busy` out 1: a load session is in progress; the CPU must stall.
- `load_ovf` out 1: sticky flag; the image exceeded the depth.
- `load_words` out DEPTH_LOG2+1: number of words written in the current or last session.

## Operation
- **States.**
  - `RUN`: the reset state.
  - `LOAD`: entered from `RUN` on `load_start`.
- **Per-word valid bits.** Each of the `2**DEPTH_LOG2` words has a valid bit. All valid bits are cleared on reset and on every accepted `load_start`. A read of a word whose valid bit is clear returns `DEFAULT_WORD` with `fetch_err`=0.
- **`RUN` state.**
  - `fetch_req`=1 registers a result for the next cycle.
  - Word index = `fetch_addr[DEPTH_LOG2+1:2]`.
  - Error condition: `fetch_addr[1:0]`≠0, or `fetch_addr[31:DEPTH_LOG2+2]`≠0.
  - On error: `fetch_instr`=`DEFAULT_WORD` and `fetch_err`=1.
- **`load_start` handling.**
  - In `RUN`: go to `LOAD`, pointer←0, `load_words`←0, `load_ovf`←0, clear valid bits.
  - In `LOAD`: restarts the session with the same actions (the previous partial image is discarded).
- **`LOAD` state.**
  - `busy`=1 and `load_ready`=1.
  - A word is accepted on `load_valid`&&`load_ready`. Then `mem[ptr]`←`load_data`, `valid[ptr]`←1, `ptr`++, `load_words`++.
  - Fetches are ignored: `fetch_valid`=0 the following cycle.
- **Leaving `LOAD`.**
  - An accepted word with `load_last`=1 returns the block to `RUN` on the next cycle.
  - An accepted word at `ptr`=DEPTH-1 with `load_last`=0 also returns to `RUN` and sets `load_ovf`=1. Later words are not accepted, and the stored image is kept.
- **Simultaneous events.**
  - `load_start` with `fetch_req` in `RUN`: the load wins and the fetch is dropped (`fetch_valid`=0).
  - `load_start` with an accepted word in `LOAD`: the restart wins and the word is discarded.

## Timing
- **Reset values:**
  - `fetch_valid`=0, `fetch_instr`=`DEFAULT_WORD`, `fetch_err`=0.
  - `load_ready`=0, `busy`=0, `load_ovf`=0, `load_words`=0.
  - State `RUN`, all valid bits cleared.
- **Fetch latency.** Request at edge N; `fetch_valid`/`fetch_instr`/`fetch_err` are valid after edge N+1 and held for one cycle. Back-to-back requests give one result per cycle. `fetch_instr` holds its last value when `fetch_valid`=0.
- **Load throughput.** One word per cycle.
  - `load_ready` and `busy` rise the cycle after `load_start`.
  - Both fall the cycle after the last or overflowing word.
  - A fetch requested in the first `RUN` cycle after a load sees the new image.
- **Reset mid-load.** The block returns to `RUN` immediately, the image is invalidated, and all fetches return `DEFAULT_WORD`.

## Test plan
- **Fetch after reset:** after reset, fetch 0x00000000 and 0x00000040 → `fetch_valid`=1 one cycle later with `fetch_instr`=0x00000000 and `fetch_err`=0.
- **Load then fetch:** load 3 words {0x08000010, 0x08000060, 0x3C0D4000} with `load_last` on the third → `load_words`=3, `busy` falls. Fetch 0x8 → 0x3C0D4000, fetch 0xC → 0x00000000.
- **Fetch errors:** with DEPTH_LOG2=8, fetch 0x00000402 → `fetch_err`=1 with `DEFAULT_WORD`. Fetch 0x00000400 → `fetch_err`=1.
- **Overflow:** stream 257 words with `load_last`=0 → 256 accepted, `load_ovf`=1, `load_ready`=0 from the cycle after word 255. Fetch 0x3FC → word 255.
- **Restart and simultaneous events:**
  - `load_start` in `LOAD` after 5 words → `load_words`=0 and earlier words read as the default.
  - `load_start` together with `fetch_req` in `RUN` → no `fetch_valid`.
- **Reset mid-load:** assert `reset`=0 mid-load → outputs are at reset values immediately; the fetch after release returns `DEFAULT_WORD`.
